// File: rtl/trend_event_fifo.sv
// Run-length event tracker for the trend bit, feeding a first-word-fall-through event FIFO.
// Optional per-entry cycle timestamps are enabled by defining TREND_EVT_TIMESTAMP_EN.
module trend_event_fifo #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trend_in,
  input  logic                     sample_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [CNT_W:0]           evt_data,
  output logic [15:0]              evt_ts,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned DW    = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             level_q;
  logic [CNT_W-1:0] run_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [DW-1:0]    mem [DEPTH];

  logic mismatch;
  logic push;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  // Event generation and FIFO accept/drop decisions
  always_comb begin
    mismatch = sample_en && (trend_in != level_q);
    push     = mismatch && (run_cnt != '0);
    full     = (count_q == CW'(DEPTH));
    pop      = evt_valid && evt_ready;
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
  end

  assign evt_valid  = (count_q != '0);
  assign evt_data   = evt_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  // Run tracking; counter saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      run_cnt <= '0;
    end else if (sample_en) begin
      if (trend_in == level_q) begin
        run_cnt <= (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_W'(1);
      end else begin
        level_q <= trend_in;
        run_cnt <= CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {level_q, run_cnt};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

`ifdef TREND_EVT_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= 16'd0;
      for (int i = 0; i < int'(DEPTH); i++) ts_mem[i] <= 16'd0;
    end else begin
      ts_q <= ts_q + 16'd1;
      if (wr_en) ts_mem[wr_ptr] <= ts_q;
    end
  end

  assign evt_ts = evt_valid ? ts_mem[rd_ptr] : 16'd0;
`else
  assign evt_ts = 16'd0;
`endif

endmodule

// File: tb/tb_trend_event_fifo.sv
// Directed self-checking bench for trend_event_fifo (CNT_W=8 main instance, CNT_W=3 saturation instance).
module tb_trend_event_fifo;

  logic       clk;
  logic       reset;
  logic       trend_in;
  logic       sample_en;
  logic       evt_ready;
  logic       clr_overflow;

  logic       evt_valid;
  logic [8:0] evt_data;
  logic [15:0] evt_ts;
  logic [2:0] fifo_count;
  logic       overflow;

  logic       evt_valid3;
  logic [3:0] evt_data3;
  logic [15:0] evt_ts3;
  logic [2:0] fifo_count3;
  logic       overflow3;

  int n_tests;
  int n_fail;

  trend_event_fifo #(.CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .trend_in(trend_in), .sample_en(sample_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .evt_ts(evt_ts),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  trend_event_fifo #(.CNT_W(3), .DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .trend_in(trend_in), .sample_en(sample_en),
    .evt_valid(evt_valid3), .evt_ready(evt_ready), .evt_data(evt_data3), .evt_ts(evt_ts3),
    .fifo_count(fifo_count3), .overflow(overflow3), .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; trend_in = 1'b0; sample_en = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; trend_in = 1'b1; sample_en = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
    step(3);
    n_tests++;
    if ({evt_valid, evt_data, fifo_count, overflow, evt_ts} !== {1'b0, 9'h000, 3'd0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h cnt=%0d ovf=%b ts=%h, want all zero",
               evt_valid, evt_data, fifo_count, overflow, evt_ts);
    end
    reset = 1'b0; sample_en = 1'b0;
  endtask

  task automatic test_first_event();
    do_reset();
    sample_en = 1'b1; trend_in = 1'b0;
    step(5);
    trend_in = 1'b1;
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL t1_no_early_valid: got %b want 0", evt_valid);
    end
    step(1);
    n_tests++;
    if ({evt_valid, evt_data, fifo_count} !== {1'b1, 9'h005, 3'd1}) begin
      n_fail++;
      $display("FAIL t1_event: got valid=%b data=%h cnt=%0d want 1/005/1", evt_valid, evt_data, fifo_count);
    end
    sample_en = 1'b0; evt_ready = 1'b1;
    step(1);
    n_tests++;
    if ({evt_valid, evt_data, fifo_count} !== {1'b0, 9'h000, 3'd0}) begin
      n_fail++;
      $display("FAIL t1_pop: got valid=%b data=%h cnt=%0d want 0/000/0", evt_valid, evt_data, fifo_count);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_first_sample_high();
    do_reset();
    sample_en = 1'b1; trend_in = 1'b1;
    step(1);
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL t2_no_zero_event: got valid=%b want 0", evt_valid);
    end
    step(2);
    trend_in = 1'b0;
    step(1);
    n_tests++;
    if ({evt_valid, evt_data, fifo_count} !== {1'b1, 9'h103, 3'd1}) begin
      n_fail++;
      $display("FAIL t2_event: got valid=%b data=%h cnt=%0d want 1/103/1", evt_valid, evt_data, fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] exp_q [4];
    exp_q[0] = 9'h001; exp_q[1] = 9'h102; exp_q[2] = 9'h003; exp_q[3] = 9'h101;
    do_reset();
    sample_en = 1'b1;
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; step(2);
    trend_in = 1'b0; step(3);
    trend_in = 1'b1; step(1);
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; step(1);
    sample_en = 1'b0;
    n_tests++;
    if ({fifo_count, overflow, evt_data} !== {3'd4, 1'b1, 9'h001}) begin
      n_fail++;
      $display("FAIL t3_full: got cnt=%0d ovf=%b head=%h want 4/1/001", fifo_count, overflow, evt_data);
    end
    step(1);
    n_tests++;
    if (evt_data !== 9'h001) begin
      n_fail++; $display("FAIL t3_hold_stable: got %h want 001", evt_data);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({evt_valid, evt_data} !== {1'b1, exp_q[i]}) begin
        n_fail++;
        $display("FAIL t3_drain[%0d]: got valid=%b data=%h want 1/%h", i, evt_valid, evt_data, exp_q[i]);
      end
      step(1);
    end
    evt_ready = 1'b0;
    n_tests++;
    if ({fifo_count, overflow} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL t3_sticky: got cnt=%0d ovf=%b want 0/1", fifo_count, overflow);
    end
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL t3_clear: got ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sample_en = 1'b1;
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; step(1);
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; step(1);
    trend_in = 1'b0; step(1);
    trend_in = 1'b1; evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    n_tests++;
    if ({fifo_count, overflow, evt_data} !== {3'd4, 1'b0, 9'h101}) begin
      n_fail++;
      $display("FAIL t4_push_pop_full: got cnt=%0d ovf=%b head=%h want 4/0/101", fifo_count, overflow, evt_data);
    end
    trend_in = 1'b0; clr_overflow = 1'b1;
    step(1);
    n_tests++;
    if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL t4_set_wins: got cnt=%0d ovf=%b want 4/1", fifo_count, overflow);
    end
    sample_en = 1'b0;
    step(1);
    clr_overflow = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL t4_clr: got ovf=%b want 0", overflow);
    end
    reset = 1'b1; #2;
    n_tests++;
    if ({evt_valid, fifo_count, evt_data} !== {1'b0, 3'd0, 9'h000}) begin
      n_fail++;
      $display("FAIL t4_reset_drop: got valid=%b cnt=%0d data=%h want 0/0/000", evt_valid, fifo_count, evt_data);
    end
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    sample_en = 1'b1; trend_in = 1'b0;
    step(12);
    trend_in = 1'b1;
    step(1);
    n_tests++;
    if ({evt_valid3, evt_data3} !== {1'b1, 4'h7}) begin
      n_fail++; $display("FAIL t5_sat3: got valid=%b data=%h want 1/7", evt_valid3, evt_data3);
    end
    n_tests++;
    if (evt_data !== 9'h00c) begin
      n_fail++; $display("FAIL t5_run12: got %h want 00c", evt_data);
    end
    do_reset();
    sample_en = 1'b1; trend_in = 1'b0;
    step(2);
    sample_en = 1'b0; trend_in = 1'b1;
    step(3);
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL t5_gap_no_event: got valid=%b want 0", evt_valid);
    end
    sample_en = 1'b1; trend_in = 1'b0;
    step(1);
    trend_in = 1'b1;
    step(1);
    n_tests++;
    if ({evt_valid, evt_data} !== {1'b1, 9'h003}) begin
      n_fail++; $display("FAIL t5_gap_run: got valid=%b data=%h want 1/003", evt_valid, evt_data);
    end
  endtask

  task automatic test_timestamp();
    logic [15:0] exp_ts;
`ifdef TREND_EVT_TIMESTAMP_EN
    exp_ts = 16'd9;
`else
    exp_ts = 16'd0;
`endif
    do_reset();
    sample_en = 1'b1; trend_in = 1'b0;
    step(9);
    trend_in = 1'b1;
    step(1);
    n_tests++;
    if ({evt_valid, evt_ts} !== {1'b1, exp_ts}) begin
      n_fail++; $display("FAIL t6_timestamp: got valid=%b ts=%0d want 1/%0d", evt_valid, evt_ts, exp_ts);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_first_event();
    test_first_sample_high();
    test_overflow();
    test_back_to_back();
    test_saturation();
    test_timestamp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
